decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV64I decode stage; sits directly downstream of the fetch stage (PC + ROM word).
//  Accepts one {pc, instr} per valid/ready handshake and decodes it combinationally:
//  register indices, sign-extended immediate, ALU op and control bits.
//  Registers the result into a single-entry pipeline register for the execute stage.
//  Handles backpressure and flush.
// PARAMETERS
//  XLEN  64  datapath width; immediates sign-extend to XLEN
//  PC_W  32  program counter width (byte address)
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     redirect from execute: drop held and incoming instruction
//  in_valid     in   1     fetch presents a valid instruction
//  in_ready     out  1     decode can accept this cycle
//  in_pc        in   PC_W  address of in_instr
//  in_instr     in   32    raw instruction word
//  out_valid    out  1     decoded bundle valid for execute
//  out_ready    in   1     execute accepts the bundle
//  out_pc       out  PC_W  pc of decoded instruction
//  out_rd       out  5     destination register
//  out_rs1      out  5     source register 1
//  out_rs2      out  5     source register 2
//  out_funct3   out  3     raw funct3; selects branch condition and load/store size
//  out_imm      out  XLEN  sign-extended immediate; 0 for R-type
//  out_alu_op   out  4     ALU operation code (package enum)
//  out_ctrl     out  9     {sys,word_op,alu_src_imm,jalr,jal,branch,mem_wr,mem_rd,reg_we}
//  out_illegal  out  1     instruction not decodable
// BEHAVIOUR
//  - Reset: out_valid=0; every payload output=0. Reset has priority over flush and accept.
//  - in_ready = !out_valid || out_ready (combinational; no bubble at full throughput).
//  - Accept when in_valid && in_ready: bundle registered at next edge.
//    Latency 1 cycle: in → out_valid.
//  - Hold: while out_valid && !out_ready, all out_* are stable and nothing is accepted.
//  - Drain: out_ready && !(in_valid && in_ready) → out_valid=0 next cycle.
//  - Flush has priority over accept: out_valid=0 next cycle and the in-flight input is dropped.
//    in_ready is still driven by the formula; fetch discards on its own redirect.
//  - Immediates:
//    - I, S, B, J: instr[31] sign-extends to XLEN.
//    - B/J: bit 0 = 0.
//    - U: {instr[31:12], 12'b0} sign-extended.
//  - Opcodes:
//    - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32: decoded.
//    - FENCE: decoded as NOP (all ctrl=0).
//    - SYSTEM funct3=0 (ecall/ebreak): sys=1.
//  - word_op=1 for OP-IMM-32 and OP-32 only.
//  - reg_we is forced 0 when rd==x0.
//  - out_illegal=1 on any of:
//    - instr[1:0]!=2'b11
//    - unknown opcode
//    - bad funct7 on OP/OP-32
//    - shamt[5]=1 on OP-IMM-32
//    - SYSTEM funct3!=0
//    When illegal, all ctrl bits are 0; the bundle still flows so execute can trap.
//  - out_alu_op: branches → SUB; loads, stores, AUIPC, JAL, JALR → ADD; LUI → PASS_B.
// STRUCTURE
//  - rv_pkg: opcode localparams, funct3/funct7 constants, ALU op enum, ctrl bit indices.
//  - Sub-module rv_imm_gen (combinational, instr → XLEN immediate).
//  - Decode logic and the pipeline register stay in decode_stage.
// TESTING
//  1. add x3,x1,x2 (0x002081B3) → rd=3, rs1=1, rs2=2, alu=ADD, reg_we=1, imm=0, 1 cycle later.
//  2. addi x1,x0,-1 (0xFFF00093) → imm=0xFFFF_FFFF_FFFF_FFFF, alu_src_imm=1, reg_we=1.
//  3. Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out_* stable;
//     on release, the next instr appears with no bubble.
//  4. flush in the same cycle as in_valid=1 → out_valid=0 next cycle; the instr never emerges.
//  5. 0x00000000 and 0xFFFFFFFF → out_illegal=1, out_ctrl=0;
//     addi x0,x0,0 (0x00000013) → reg_we=0, illegal=0.
//  6. rst asserted while out_valid=1 and stalled → next cycle out_valid=0 and all outputs 0.

Source files
------------

// File: rtl/rv_pkg.sv
// RV64I decode constants: opcodes, funct3/funct7 values, ALU operation enum and
// bit positions inside the ctrl bundle handed to execute.
package rv_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam int unsigned CTRL_REG_WE      = 0;
  localparam int unsigned CTRL_MEM_RD      = 1;
  localparam int unsigned CTRL_MEM_WR      = 2;
  localparam int unsigned CTRL_BRANCH      = 3;
  localparam int unsigned CTRL_JAL         = 4;
  localparam int unsigned CTRL_JALR        = 5;
  localparam int unsigned CTRL_ALU_SRC_IMM = 6;
  localparam int unsigned CTRL_WORD_OP     = 7;
  localparam int unsigned CTRL_SYS         = 8;
  localparam int unsigned CTRL_W           = 9;

  // alt selects SUB/SRA; callers decide which instruction bit carries it
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the opcode and sign-extends
// to XLEN. R-type and unrecognised opcodes yield zero.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_JAL:
        imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: combinational decode of the fetched word into a single-entry
// valid/ready pipeline register feeding execute, with flush and backpressure.
module decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [31:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_funct3,
  output logic [XLEN-1:0]     out_imm,
  output logic [3:0]          out_alu_op,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic                out_illegal
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        dec_rd;
  logic [XLEN-1:0]   dec_imm;
  alu_op_e           dec_alu;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign dec_rd = in_instr[11:7];

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (dec_imm)
  );

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_ctrl    = '0;
    dec_illegal = (in_instr[1:0] != 2'b11);
    case (opcode)
      OPC_LUI: begin
        dec_ctrl[CTRL_REG_WE]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        dec_alu                    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_ctrl[CTRL_REG_WE]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OPC_JAL: begin
        dec_ctrl[CTRL_JAL]    = 1'b1;
        dec_ctrl[CTRL_REG_WE] = 1'b1;
      end
      OPC_JALR: begin
        dec_ctrl[CTRL_JALR]        = 1'b1;
        dec_ctrl[CTRL_REG_WE]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ctrl[CTRL_BRANCH] = 1'b1;
        dec_alu               = ALU_SUB;
      end
      OPC_LOAD: begin
        dec_ctrl[CTRL_MEM_RD]      = 1'b1;
        dec_ctrl[CTRL_REG_WE]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OPC_STORE: begin
        dec_ctrl[CTRL_MEM_WR]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_ctrl[CTRL_REG_WE]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        // instr[30] is immediate data for addi; it only selects SRAI vs SRLI
        dec_alu = alu_from_funct3(f3, (f3 == F3_SRL_SRA) && in_instr[30]);
      end
      OPC_OP: begin
        dec_ctrl[CTRL_REG_WE] = 1'b1;
        dec_alu = alu_from_funct3(f3, in_instr[30]);
        if (!((f7 == F7_BASE) ||
              ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)))))
          dec_illegal = 1'b1;
      end
      OPC_OP_IMM_32: begin
        dec_ctrl[CTRL_REG_WE]      = 1'b1;
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        dec_ctrl[CTRL_WORD_OP]     = 1'b1;
        dec_alu = alu_from_funct3(f3, (f3 == F3_SRL_SRA) && in_instr[30]);
        if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
          if (in_instr[25]) dec_illegal = 1'b1;
        end else if (f3 != F3_ADD_SUB) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_32: begin
        dec_ctrl[CTRL_REG_WE]  = 1'b1;
        dec_ctrl[CTRL_WORD_OP] = 1'b1;
        dec_alu = alu_from_funct3(f3, in_instr[30]);
        if (f3 == F3_SLL) begin
          if (f7 != F7_BASE) dec_illegal = 1'b1;
        end else if (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA) begin
          if (f7 != F7_BASE && f7 != F7_ALT) dec_illegal = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        if (f3 == 3'b000) dec_ctrl[CTRL_SYS] = 1'b1;
        else              dec_illegal        = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_rd == 5'd0) dec_ctrl[CTRL_REG_WE] = 1'b0;
    if (dec_illegal)    dec_ctrl              = '0;
  end

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  alu_op_e           alu_q, alu_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    funct3_d  = funct3_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      rd_d      = dec_rd;
      rs1_d     = in_instr[19:15];
      rs2_d     = in_instr[24:20];
      funct3_d  = f3;
      imm_d     = (opcode == OPC_OP || opcode == OPC_OP_32) ? '0 : dec_imm;
      alu_d     = dec_alu;
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      imm_q     <= '0;
      alu_q     <= ALU_ADD;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      funct3_q  <= funct3_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_funct3  = funct3_q;
  assign out_imm     = imm_q;
  assign out_alu_op  = alu_q;
  assign out_ctrl    = ctrl_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of hand-decoded instructions streamed
// back to back, then backpressure, flush and reset-while-stalled sequences.
module tb_decode_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_pc, in_instr, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [63:0] out_imm;
  logic [3:0]  out_alu_op;
  logic [8:0]  out_ctrl;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(64), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic [8:0]  ctrl;
    logic        ill;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [31:0] instr, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic [63:0] imm,
                              alu_op_e alu, logic [8:0] ctrl, logic ill);
    vec_t v;
    v.instr = instr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3;
    v.imm = imm; v.alu = alu; v.ctrl = ctrl; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_payload(input string tag);
    chk({tag, "_pc"},  64'(out_pc), 64'h0);
    chk({tag, "_rd"},  64'(out_rd), 64'h0);
    chk({tag, "_rs1"}, 64'(out_rs1), 64'h0);
    chk({tag, "_rs2"}, 64'(out_rs2), 64'h0);
    chk({tag, "_f3"},  64'(out_funct3), 64'h0);
    chk({tag, "_imm"}, out_imm, 64'h0);
    chk({tag, "_alu"}, 64'(out_alu_op), 64'h0);
    chk({tag, "_ctrl"}, 64'(out_ctrl), 64'h0);
    chk({tag, "_ill"}, 64'(out_illegal), 64'h0);
  endtask

  initial begin
    //            instr         rd  rs1 rs2 f3 imm                     alu         ctrl    ill
    vecs[0]  = mk(32'h002081B3, 3,  1,  2,  0, 64'h0,                  ALU_ADD,    9'h001, 0); // add x3,x1,x2
    vecs[1]  = mk(32'hFFF00093, 1,  0,  31, 0, 64'hFFFFFFFFFFFFFFFF,   ALU_ADD,    9'h041, 0); // addi x1,x0,-1
    vecs[2]  = mk(32'h00000013, 0,  0,  0,  0, 64'h0,                  ALU_ADD,    9'h040, 0); // nop, rd=x0
    vecs[3]  = mk(32'h00000000, 0,  0,  0,  0, 64'h0,                  ALU_ADD,    9'h000, 1);
    vecs[4]  = mk(32'hFFFFFFFF, 31, 31, 31, 7, 64'h0,                  ALU_ADD,    9'h000, 1);
    vecs[5]  = mk(32'h800002B7, 5,  0,  0,  0, 64'hFFFFFFFF80000000,   ALU_PASS_B, 9'h041, 0); // lui
    vecs[6]  = mk(32'hFE208EE3, 29, 1,  2,  0, 64'hFFFFFFFFFFFFFFFC,   ALU_SUB,    9'h008, 0); // beq -4
    vecs[7]  = mk(32'h0020A423, 8,  1,  2,  2, 64'h8,                  ALU_ADD,    9'h044, 0); // sw
    vecs[8]  = mk(32'h001000EF, 1,  0,  1,  0, 64'h800,                ALU_ADD,    9'h011, 0); // jal +2048
    vecs[9]  = mk(32'h0200909B, 1,  1,  0,  1, 64'h20,                 ALU_SLL,    9'h000, 1); // slliw shamt 32
    vecs[10] = mk(32'h407302B3, 5,  6,  7,  0, 64'h0,                  ALU_SUB,    9'h001, 0); // sub
    vecs[11] = mk(32'h02208133, 2,  1,  2,  0, 64'h0,                  ALU_ADD,    9'h000, 1); // mul
    vecs[12] = mk(32'h00000073, 0,  0,  0,  0, 64'h0,                  ALU_ADD,    9'h100, 0); // ecall
    vecs[13] = mk(32'h30001073, 0,  0,  0,  1, 64'h300,                ALU_ADD,    9'h000, 1); // csrrw
    vecs[14] = mk(32'h003100BB, 1,  2,  3,  0, 64'h0,                  ALU_ADD,    9'h081, 0); // addw
    vecs[15] = mk(32'hFF813203, 4,  2,  24, 3, 64'hFFFFFFFFFFFFFFF8,   ALU_ADD,    9'h043, 0); // ld -8
    vecs[16] = mk(32'h12345397, 7,  8,  3,  5, 64'h12345000,           ALU_ADD,    9'h041, 0); // auipc
    vecs[17] = mk(32'h43F0D093, 1,  1,  31, 5, 64'h43F,                ALU_SRA,    9'h041, 0); // srai 63
    vecs[18] = mk(32'h0FF0000F, 0,  0,  31, 0, 64'h0,                  ALU_ADD,    9'h000, 0); // fence

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk_zero_payload("rst");

    // Back-to-back stream: each bundle appears one edge after acceptance.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(4 * i);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
      chk($sformatf("v%0d_pc", i),    64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
      chk($sformatf("v%0d_rd", i),    64'(out_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i),   64'(out_rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i),   64'(out_rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d_f3", i),    64'(out_funct3), 64'(vecs[i].f3));
      chk($sformatf("v%0d_imm", i),   out_imm, vecs[i].imm);
      chk($sformatf("v%0d_alu", i),   64'(out_alu_op), 64'(vecs[i].alu));
      chk($sformatf("v%0d_ctrl", i),  64'(out_ctrl), 64'(vecs[i].ctrl));
      chk($sformatf("v%0d_ill", i),   64'(out_illegal), 64'(vecs[i].ill));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", 64'(out_valid), 64'h0);

    // Backpressure: hold add for 3 stalled cycles, then addi follows with no bubble.
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h2000;
    @(posedge clk); #1;
    chk("bp_first_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b0; in_instr = 32'hFFF00093; in_pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'h0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'h1);
      chk($sformatf("bp%0d_rd", c),    64'(out_rd), 64'h3);
      chk($sformatf("bp%0d_pc", c),    64'(out_pc), 64'h2000);
      chk($sformatf("bp%0d_ctrl", c),  64'(out_ctrl), 64'h001);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    chk("bp_next_valid", 64'(out_valid), 64'h1);
    chk("bp_next_pc",    64'(out_pc), 64'h2004);
    chk("bp_next_imm",   out_imm, 64'hFFFFFFFFFFFFFFFF);

    // Flush with a valid incoming instruction: it never emerges.
    flush = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h3000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_pc_not_loaded", 64'(out_pc), 64'h2004);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("flush%0d_valid", c), 64'(out_valid), 64'h0);
    end

    // Reset while stalled with a valid bundle and a pending input.
    in_valid = 1'b1; in_instr = 32'hFE208EE3; in_pc = 32'h4000; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rs_loaded_valid", 64'(out_valid), 64'h1);
    chk("rs_loaded_pc", 64'(out_pc), 64'h4000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rs_valid", 64'(out_valid), 64'h0);
    chk_zero_payload("rs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
